// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: drives every input pattern into an N-input combinational
// cell, captures its output into a truth table and compares the result
// against a reference truth table.
module tt_sweep_capture #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1,
    localparam int TT_W  = 1 << N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected_tt,
    output logic [N_IN-1:0] x,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt_out,
    output logic            tt_valid,
    output logic            match
);

    localparam int IDX_W = N_IN + 1;
    localparam logic [3:0]       CNT_LAST = 4'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [3:0]       cnt_q;
    logic [N_IN-1:0]  x_q;
    logic [TT_W-1:0]  tt_q;
    logic [TT_W-1:0]  tt_d;
    logic             busy_q;
    logic             done_q;
    logic             tt_valid_q;
    logic             match_q;

    // Truth table with the current sample inserted, so the final compare sees it too
    always_comb begin
        idx_d = idx_q + 1'b1;
        tt_d  = tt_q;
        tt_d[idx_q[N_IN-1:0]] = y_in;
    end

    // Sweep controller: pattern stepping, capture, completion and abort
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            x_q        <= '0;
            tt_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tt_valid_q <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_q    <= S_RUN;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        x_q        <= '0;
                        tt_q       <= '0;
                        busy_q     <= 1'b1;
                        tt_valid_q <= 1'b0;
                        match_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b0;
                        tt_valid_q <= 1'b0;
                        match_q    <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        tt_q <= tt_d;
                        if (idx_q == IDX_LAST) begin
                            state_q    <= S_DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            tt_valid_q <= 1'b1;
                            match_q    <= (tt_d == expected_tt);
                        end else begin
                            idx_q <= idx_d;
                            x_q   <= idx_d[N_IN-1:0];
                            cnt_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    if (abort) begin
                        tt_valid_q <= 1'b0;
                        match_q    <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign x        = x_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tt_out   = tt_q;
    assign tt_valid = tt_valid_q;
    assign match    = match_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: three instances (N=4/S=1, N=4/S=3, N=1/S=1)
// with behavioural cell models and a scoreboard of expected sweep results.
module tb_tt_sweep_capture;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] tt;
        logic        m;
    } sb_t;
    sb_t sb_q[$];

    logic [15:0] cell_tt = 16'h0168;

    // Instance A: N_IN=4, SETTLE=1, combinational cell
    logic        start_a = 1'b0, abort_a = 1'b0, y_a;
    logic [15:0] exp_a = '0, tt_a;
    logic [3:0]  x_a;
    logic        busy_a, done_a, valid_a, match_a;
    assign y_a = cell_tt[x_a];

    tt_sweep_capture #(.N_IN(4), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .expected_tt(exp_a), .x(x_a), .y_in(y_a), .busy(busy_a),
        .done(done_a), .tt_out(tt_a), .tt_valid(valid_a), .match(match_a)
    );

    // Instance B: N_IN=4, SETTLE=3, cell with 2-cycle output delay
    logic        start_b = 1'b0, abort_b = 1'b0, y_b;
    logic        d1_b = 1'b0, d2_b = 1'b0;
    logic [15:0] exp_b = '0, tt_b;
    logic [3:0]  x_b;
    logic        busy_b, done_b, valid_b, match_b;
    always @(posedge clk) begin
        d1_b <= cell_tt[x_b];
        d2_b <= d1_b;
    end
    assign y_b = d2_b;

    tt_sweep_capture #(.N_IN(4), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .expected_tt(exp_b), .x(x_b), .y_in(y_b), .busy(busy_b),
        .done(done_b), .tt_out(tt_b), .tt_valid(valid_b), .match(match_b)
    );

    // Instance C: N_IN=1, SETTLE=1, inverter cell
    logic       start_c = 1'b0, abort_c = 1'b0, y_c;
    logic [1:0] exp_c = '0, tt_c;
    logic [0:0] x_c;
    logic       busy_c, done_c, valid_c, match_c;
    assign y_c = ~x_c[0];

    tt_sweep_capture #(.N_IN(1), .SETTLE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c),
        .expected_tt(exp_c), .x(x_c), .y_in(y_c), .busy(busy_c),
        .done(done_c), .tt_out(tt_c), .tt_valid(valid_c), .match(match_c)
    );

    // Done pulse counter for instance A
    int dcnt_a = 0;
    always @(negedge clk) if (done_a === 1'b1) dcnt_a++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int sel, input int budget, output int n);
        logic d;
        n = 0;
        d = 1'b0;
        while (!d && n < budget) begin
            tick();
            n++;
            case (sel)
                0: d = (done_a === 1'b1);
                1: d = (done_b === 1'b1);
                default: d = (done_c === 1'b1);
            endcase
        end
    endtask

    task automatic sb_check(input string tag, input logic [15:0] tt, input logic m);
        sb_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_tt"}, 32'(tt), 32'(e.tt));
            chk({tag, "_match"}, 32'(m), 32'(e.m));
        end
    endtask

    initial begin
        int n;
        int dbase;

        // Reset
        tick();
        tick();
        chk("rst_x", 32'(x_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_tt", 32'(tt_a), 0);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_match", 32'(match_a), 0);
        chk("rst_tt_b", 32'(tt_b), 0);
        chk("rst_x_c", 32'(x_c), 0);
        rst_n = 1'b1;
        tick();

        // Basic sweep, matching reference
        exp_a = 16'h0168;
        start_a = 1'b1;
        sb_q.push_back('{tt: 16'h0168, m: 1'b1});
        tick();
        start_a = 1'b0;
        chk("basic_busy0", 32'(busy_a), 1);
        chk("basic_x0", 32'(x_a), 0);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("basic_x_step", 32'(x_a), 32'(k));
        end
        tick();
        chk("basic_done", 32'(done_a), 1);
        chk("basic_busy_end", 32'(busy_a), 0);
        chk("basic_valid", 32'(valid_a), 1);
        chk("basic_x_hold", 32'(x_a), 15);
        sb_check("basic", tt_a, match_a);
        // start in DONE ignored; reference changing afterwards does not disturb match
        start_a = 1'b1;
        exp_a = 16'h0000;
        tick();
        start_a = 1'b0;
        chk("done_pulse_end", 32'(done_a), 0);
        chk("start_in_done_ignored", 32'(busy_a), 0);
        chk("hold_valid", 32'(valid_a), 1);
        chk("hold_match", 32'(match_a), 1);
        chk("hold_tt", 32'(tt_a), 32'h0168);
        tick();

        // Mismatch
        dbase = dcnt_a;
        exp_a = 16'h0169;
        start_a = 1'b1;
        sb_q.push_back('{tt: 16'h0168, m: 1'b0});
        tick();
        start_a = 1'b0;
        wait_done(0, 40, n);
        chk("mis_latency", 32'(n), 16);
        sb_check("mismatch", tt_a, match_a);
        chk("mis_valid", 32'(valid_a), 1);
        tick();
        tick();
        chk("mis_done_once", 32'(dcnt_a - dbase), 1);

        // Settle timing with delayed cell
        exp_b = 16'h0168;
        start_b = 1'b1;
        sb_q.push_back('{tt: 16'h0168, m: 1'b1});
        tick();
        start_b = 1'b0;
        chk("settle_x0", 32'(x_b), 0);
        for (int j = 1; j < 48; j++) begin
            tick();
            chk("settle_x_hold", 32'(x_b), 32'(j / 3));
        end
        tick();
        chk("settle_done_at_48", 32'(done_b), 1);
        sb_check("settle", tt_b, match_b);

        // Abort at capture edge 7
        dbase = dcnt_a;
        exp_a = 16'h0168;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_valid", 32'(valid_a), 0);
        chk("abort_match", 32'(match_a), 0);
        chk("abort_done", 32'(done_a), 0);
        chk("abort_x_held", 32'(x_a), 6);
        chk("abort_partial_tt", 32'(tt_a), 32'h0028);
        for (int k = 0; k < 20; k++) tick();
        chk("abort_no_done", 32'(dcnt_a - dbase), 0);
        start_a = 1'b1;
        sb_q.push_back('{tt: 16'h0168, m: 1'b1});
        tick();
        start_a = 1'b0;
        wait_done(0, 40, n);
        chk("post_abort_latency", 32'(n), 16);
        sb_check("post_abort", tt_a, match_a);
        tick();

        // start while busy is ignored
        dbase = dcnt_a;
        start_a = 1'b1;
        sb_q.push_back('{tt: 16'h0168, m: 1'b1});
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("busy_start_x", 32'(x_a), 5);
        chk("busy_start_busy", 32'(busy_a), 1);
        wait_done(0, 40, n);
        chk("busy_start_latency", 32'(n), 11);
        sb_check("busy_start", tt_a, match_a);
        for (int k = 0; k < 20; k++) tick();
        chk("busy_start_done_count", 32'(dcnt_a - dbase), 1);

        // Reset mid-sweep at capture edge 10
        dbase = dcnt_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_x", 32'(x_a), 0);
        chk("midrst_tt", 32'(tt_a), 0);
        chk("midrst_busy", 32'(busy_a), 0);
        chk("midrst_valid", 32'(valid_a), 0);
        chk("midrst_match", 32'(match_a), 0);
        chk("midrst_done", 32'(done_a), 0);
        for (int k = 0; k < 20; k++) tick();
        chk("midrst_no_done", 32'(dcnt_a - dbase), 0);

        // N_IN=1 boundary
        exp_c = 2'b01;
        start_c = 1'b1;
        sb_q.push_back('{tt: 16'h0001, m: 1'b1});
        tick();
        start_c = 1'b0;
        wait_done(2, 10, n);
        chk("n1_latency", 32'(n), 2);
        chk("n1_valid", 32'(valid_c), 1);
        sb_check("n1", {14'd0, tt_c}, match_c);

        // start and abort together in IDLE
        dbase = dcnt_a;
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("start_abort_busy", 32'(busy_a), 0);
        for (int k = 0; k < 20; k++) tick();
        chk("start_abort_busy_later", 32'(busy_a), 0);
        chk("start_abort_no_done", 32'(dcnt_a - dbase), 0);

        chk("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
